video_cmd_queue: RTL and testbench

// Parametrised DMA command front end for the video accelerator. It holds N_QUEUE independent
// 64-bit command FIFOs, each filled by pairs of 32-bit register writes and drained by one data

---
 rtl/video_cmd_queue.sv | 184 ++++++++++++++++++
 tb/tb_video_cmd_queue.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_cmd_queue.sv
// Multi-queue 64-bit DMA command front end: register-written command pairs are queued per mover,
// with per-queue status, error flags, flush, saturating completion counters and a shared irq.
module video_cmd_queue #(
    parameter int unsigned N_QUEUE    = 2,
    parameter int unsigned DEPTH_LOG2 = 7,
    parameter int unsigned DONE_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  reg_en,
    input  logic [3:0]            reg_we,
    input  logic [11:0]           reg_addr,
    input  logic [31:0]           reg_wdata,
    output logic [31:0]           reg_rdata,
    output logic [N_QUEUE-1:0]    cmd_valid,
    output logic [64*N_QUEUE-1:0] cmd_data,
    input  logic [N_QUEUE-1:0]    cmd_ready,
    input  logic [N_QUEUE-1:0]    cmd_done,
    output logic                  irq
);
    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam int unsigned LvlW  = DEPTH_LOG2 + 1;
    localparam logic [DONE_WIDTH-1:0] DoneMax = '1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [LvlW-1:0]       lvl_t;

    logic [63:0]           mem_q [N_QUEUE][Depth];
    ptr_t                  rd_ptr_q [N_QUEUE];
    ptr_t                  rd_ptr_d [N_QUEUE];
    ptr_t                  wr_ptr_q [N_QUEUE];
    ptr_t                  wr_ptr_d [N_QUEUE];
    lvl_t                  level_q  [N_QUEUE];
    lvl_t                  level_d  [N_QUEUE];
    logic [31:0]           low_q    [N_QUEUE];
    logic [31:0]           low_d    [N_QUEUE];
    logic [DONE_WIDTH-1:0] done_q   [N_QUEUE];
    logic [DONE_WIDTH-1:0] done_d   [N_QUEUE];
    logic [1:0]            irq_en_q [N_QUEUE];
    logic [1:0]            irq_en_d [N_QUEUE];
    logic [N_QUEUE-1:0]    low_pending_q, low_pending_d;
    logic [N_QUEUE-1:0]    ovf_q, ovf_d, seq_q, seq_d;
    logic [N_QUEUE-1:0]    push, pop, q_hit, q_full, q_flush;
    logic [31:0]           rdata_q, rdata_d;
    logic                  irq_q, irq_d;

    logic       reg_write;
    logic [7:0] reg_sel;
    logic [3:0] reg_off;

    assign reg_write = reg_en && (reg_we == 4'hF);
    assign reg_sel   = reg_addr[11:4];
    assign reg_off   = reg_addr[3:0];

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        level_d       = level_q;
        low_d         = low_q;
        done_d        = done_q;
        irq_en_d      = irq_en_q;
        low_pending_d = low_pending_q;
        ovf_d         = ovf_q;
        seq_d         = seq_q;
        push          = '0;
        pop           = '0;
        q_hit         = '0;
        q_full        = '0;
        q_flush       = '0;
        rdata_d       = reg_en ? 32'h0 : rdata_q;
        irq_d         = 1'b0;
        for (int q = 0; q < N_QUEUE; q++) begin
            q_hit[q]  = (reg_sel == 8'(q));
            q_full[q] = (level_q[q] == lvl_t'(Depth));
            pop[q]    = (level_q[q] != '0) && cmd_ready[q];
            // Reads see pre-write state; unmapped offsets fall through to zero.
            if (reg_en && q_hit[q]) begin
                case (reg_off)
                    4'h0: rdata_d = 32'(level_q[q]);
                    4'h4: rdata_d = {27'b0, seq_q[q], ovf_q[q], low_pending_q[q], q_full[q],
                                     level_q[q] == '0};
                    4'h8: rdata_d = 32'(done_q[q]);
                    4'hC: rdata_d = {30'b0, irq_en_q[q]};
                    default: rdata_d = 32'h0;
                endcase
            end
            if (reg_write && q_hit[q]) begin
                case (reg_off)
                    4'h0: begin
                        low_d[q]         = reg_wdata;
                        low_pending_d[q] = 1'b1;
                    end
                    4'h4: begin
                        if (!low_pending_q[q]) begin
                            seq_d[q] = 1'b1;
                        end else if (q_full[q]) begin
                            ovf_d[q]         = 1'b1;
                            low_pending_d[q] = 1'b0;
                        end else begin
                            push[q]          = 1'b1;
                            low_pending_d[q] = 1'b0;
                        end
                    end
                    4'h8: begin
                        q_flush[q] = reg_wdata[0];
                        if (reg_wdata[1]) begin
                            ovf_d[q] = 1'b0;
                            seq_d[q] = 1'b0;
                        end
                    end
                    4'hC: irq_en_d[q] = reg_wdata[1:0];
                    default: ;
                endcase
            end
            done_d[q] = (reg_write && q_hit[q] && reg_off == 4'h8 && reg_wdata[2]) ? '0
                                                                                 : done_q[q];
            if (cmd_done[q] && done_d[q] != DoneMax) begin
                done_d[q] = done_d[q] + DONE_WIDTH'(1);
            end
            // Flush wins over a same-cycle pop.
            if (q_flush[q]) begin
                level_d[q]       = '0;
                rd_ptr_d[q]      = '0;
                wr_ptr_d[q]      = '0;
                low_pending_d[q] = 1'b0;
            end else begin
                if (push[q]) wr_ptr_d[q] = wr_ptr_q[q] + ptr_t'(1);
                if (pop[q])  rd_ptr_d[q] = rd_ptr_q[q] + ptr_t'(1);
                level_d[q] = level_q[q] + lvl_t'(push[q]) - lvl_t'(pop[q]);
            end
            irq_d = irq_d | (irq_en_q[q][0] && done_q[q] != '0)
                          | (irq_en_q[q][1] && (ovf_q[q] || seq_q[q]));
        end
    end

    always_comb begin
        cmd_valid = '0;
        cmd_data  = '0;
        for (int q = 0; q < N_QUEUE; q++) begin
            cmd_valid[q]        = (level_q[q] != '0);
            cmd_data[64*q +: 64] = mem_q[q][rd_ptr_q[q]];
        end
    end

    always_ff @(posedge aclk) begin
        for (int q = 0; q < N_QUEUE; q++) begin
            if (push[q]) mem_q[q][wr_ptr_q[q]] <= {reg_wdata, low_q[q]};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int q = 0; q < N_QUEUE; q++) begin
                rd_ptr_q[q] <= '0;
                wr_ptr_q[q] <= '0;
                level_q[q]  <= '0;
                low_q[q]    <= '0;
                done_q[q]   <= '0;
                irq_en_q[q] <= '0;
            end
            low_pending_q <= '0;
            ovf_q         <= '0;
            seq_q         <= '0;
            rdata_q       <= '0;
            irq_q         <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            level_q       <= level_d;
            low_q         <= low_d;
            done_q        <= done_d;
            irq_en_q      <= irq_en_d;
            low_pending_q <= low_pending_d;
            ovf_q         <= ovf_d;
            seq_q         <= seq_d;
            rdata_q       <= rdata_d;
            irq_q         <= irq_d;
        end
    end

    assign reg_rdata = rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_video_cmd_queue.sv
// Bench for video_cmd_queue: queue-based reference model compared every cycle, plus directed
// scenarios with literal expectations.
module tb_video_cmd_queue;
    localparam int NQ    = 2;
    localparam int DL    = 7;
    localparam int DEPTH = 128;
    localparam int DMAX  = 65535;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            reg_en;
    logic [3:0]      reg_we;
    logic [11:0]     reg_addr;
    logic [31:0]     reg_wdata;
    logic [31:0]     reg_rdata;
    logic [NQ-1:0]   cmd_valid;
    logic [64*NQ-1:0] cmd_data;
    logic [NQ-1:0]   cmd_ready;
    logic [NQ-1:0]   cmd_done;
    logic            irq;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    video_cmd_queue #(.N_QUEUE(NQ), .DEPTH_LOG2(DL), .DONE_WIDTH(16)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .reg_en    (reg_en),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .cmd_done  (cmd_done),
        .irq       (irq)
    );

    always #5 aclk = ~aclk;

    // Reference model state
    logic [63:0] mq [NQ][$];
    logic [31:0] mlow [NQ];
    bit          mlp [NQ];
    bit          movf [NQ];
    bit          mseq [NQ];
    int          mdone [NQ];
    logic [1:0]  men [NQ];
    logic [31:0] m_rdata;
    logic        m_irq;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int q = 0; q < NQ; q++) begin
            mq[q].delete();
            mlow[q] = '0;
            mlp[q]  = 1'b0;
            movf[q] = 1'b0;
            mseq[q] = 1'b0;
            mdone[q] = 0;
            men[q]  = '0;
        end
        m_rdata = '0;
        m_irq   = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        int qi;
        int off;
        qi  = int'(a[11:4]);
        off = int'(a[3:0]);
        if (qi >= NQ) return 32'h0;
        case (off)
            0:  return 32'(mq[qi].size());
            4:  return {27'b0, mseq[qi], movf[qi], mlp[qi], mq[qi].size() == DEPTH,
                        mq[qi].size() == 0};
            8:  return 32'(mdone[qi]);
            12: return {30'b0, men[qi]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_step();
        logic        irq_n;
        bit          wr;
        int          qi;
        int          off;
        bit          popq [NQ];
        bit          fullq [NQ];
        logic [31:0] rd_n;
        rd_n  = reg_en ? m_read(reg_addr) : m_rdata;
        irq_n = 1'b0;
        for (int q = 0; q < NQ; q++) begin
            irq_n = irq_n | (men[q][0] && mdone[q] != 0) | (men[q][1] && (movf[q] || mseq[q]));
            popq[q]  = (mq[q].size() > 0) && cmd_ready[q];
            fullq[q] = (mq[q].size() == DEPTH);
        end
        wr  = reg_en && (reg_we == 4'hF);
        qi  = int'(reg_addr[11:4]);
        off = int'(reg_addr[3:0]);
        for (int q = 0; q < NQ; q++) begin
            bit hit;
            hit = wr && (qi == q);
            if (hit && off == 8 && reg_wdata[2]) mdone[q] = 0;
            if (cmd_done[q] && mdone[q] < DMAX) mdone[q]++;
            if (hit && off == 8 && reg_wdata[1]) begin
                movf[q] = 1'b0;
                mseq[q] = 1'b0;
            end
            if (hit && off == 12) men[q] = reg_wdata[1:0];
            if (hit && off == 8 && reg_wdata[0]) begin
                mq[q].delete();
                mlp[q] = 1'b0;
            end else begin
                if (popq[q]) void'(mq[q].pop_front());
                if (hit && off == 4) begin
                    if (!mlp[q]) mseq[q] = 1'b1;
                    else if (fullq[q]) begin
                        movf[q] = 1'b1;
                        mlp[q]  = 1'b0;
                    end else begin
                        mq[q].push_back({reg_wdata, mlow[q]});
                        mlp[q] = 1'b0;
                    end
                end
                if (hit && off == 0) begin
                    mlow[q] = reg_wdata;
                    mlp[q]  = 1'b1;
                end
            end
        end
        m_irq   = irq_n;
        m_rdata = rd_n;
    endtask

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) m_reset();
        else m_step();
    end

    always @(negedge aclk) begin
        if (chk_en) begin
            for (int q = 0; q < NQ; q++) begin
                chk($sformatf("model cmd_valid[%0d]", q), 64'(cmd_valid[q]),
                    64'(mq[q].size() != 0));
                if (mq[q].size() != 0)
                    chk($sformatf("model cmd_data[%0d]", q), cmd_data[64*q +: 64], mq[q][0]);
            end
            chk("model irq", 64'(irq), 64'(m_irq));
            chk("model reg_rdata", 64'(reg_rdata), 64'(m_rdata));
        end
    end

    // One clock of register-port activity; cmd_done is a one-cycle pulse.
    task automatic op(input logic en, input logic [3:0] we, input logic [11:0] a,
                      input logic [31:0] d);
        reg_en    = en;
        reg_we    = we;
        reg_addr  = a;
        reg_wdata = d;
        @(posedge aclk);
        #1;
        reg_en   = 1'b0;
        reg_we   = 4'h0;
        cmd_done = '0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        op(1'b1, 4'hF, a, d);
    endtask

    task automatic idle();
        op(1'b0, 4'h0, 12'h0, 32'h0);
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        op(1'b1, 4'h0, a, 32'h0);
        chk(name, 64'(reg_rdata), 64'(exp));
    endtask

    initial begin
        aresetn   = 1'b0;
        reg_en    = 1'b0;
        reg_we    = 4'h0;
        reg_addr  = '0;
        reg_wdata = '0;
        cmd_ready = '0;
        cmd_done  = '0;
        m_reset();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk_en = 1'b1;

        // Reset state
        chk("reset cmd_valid", 64'(cmd_valid), 64'h0);
        chk("reset irq", 64'(irq), 64'h0);
        rd_chk("reset status q0", 12'h004, 32'h1);
        rd_chk("reset level q0", 12'h000, 32'h0);

        // 1: single command pair on queue 0
        wr(12'h000, 32'h1);
        wr(12'h004, 32'h2);
        chk("t1 cmd_valid0", 64'(cmd_valid[0]), 64'h1);
        chk("t1 cmd_data0", cmd_data[63:0], 64'h0000_0002_0000_0001);
        rd_chk("t1 level q0", 12'h000, 32'h1);
        cmd_ready[0] = 1'b1;
        idle();
        cmd_ready[0] = 1'b0;
        chk("t1 drained", 64'(cmd_valid[0]), 64'h0);

        // 2: fill queue 1 then overflow
        for (int i = 0; i < DEPTH; i++) begin
            wr(12'h010, 32'(i));
            wr(12'h014, 32'hA000_0000 | 32'(i));
        end
        rd_chk("t2 level full", 12'h010, 32'd128);
        chk("t2 head q1", cmd_data[127:64], 64'hA000_0000_0000_0000);
        wr(12'h010, 32'hDEAD);
        wr(12'h014, 32'hBEEF);
        rd_chk("t2 status ovf", 12'h014, 32'hA);
        rd_chk("t2 level stays", 12'h010, 32'd128);
        wr(12'h018, 32'h2);
        rd_chk("t2 ovf cleared", 12'h014, 32'h2);
        wr(12'h018, 32'h1);
        rd_chk("t2 flushed", 12'h014, 32'h1);

        // 3: high word without staged low
        wr(12'h00C, 32'h2);
        wr(12'h004, 32'h5);
        chk("t3 irq not yet", 64'(irq), 64'h0);
        idle();
        chk("t3 irq", 64'(irq), 64'h1);
        rd_chk("t3 status seq", 12'h004, 32'h11);
        rd_chk("t3 level", 12'h000, 32'h0);
        wr(12'h008, 32'h2);
        wr(12'h00C, 32'h0);
        idle();
        chk("t3 irq cleared", 64'(irq), 64'h0);

        // Partial byte enables are not writes
        op(1'b1, 4'h3, 12'h000, 32'h7);
        wr(12'h004, 32'h9);
        chk("partial we no push", 64'(cmd_valid), 64'h0);
        rd_chk("partial we seq", 12'h004, 32'h11);
        wr(12'h008, 32'h2);

        // Unmapped queue and offset
        rd_chk("unmapped offset", 12'h002, 32'h0);
        rd_chk("unmapped queue", 12'h020, 32'h0);
        wr(12'h020, 32'h1);
        wr(12'h024, 32'h2);
        chk("unmapped write ignored", 64'(cmd_valid), 64'h0);

        // 4: in-order drain, then flush during pop
        wr(12'h000, 32'h11); wr(12'h004, 32'h21);
        wr(12'h000, 32'h12); wr(12'h004, 32'h22);
        wr(12'h000, 32'h13); wr(12'h004, 32'h23);
        cmd_ready[0] = 1'b1;
        chk("t4 first", cmd_data[63:0], 64'h0000_0021_0000_0011);
        idle();
        chk("t4 second", cmd_data[63:0], 64'h0000_0022_0000_0012);
        idle();
        chk("t4 third", cmd_data[63:0], 64'h0000_0023_0000_0013);
        idle();
        chk("t4 empty", 64'(cmd_valid[0]), 64'h0);
        cmd_ready[0] = 1'b0;
        wr(12'h000, 32'h31); wr(12'h004, 32'h41);
        wr(12'h000, 32'h32); wr(12'h004, 32'h42);
        cmd_ready[0] = 1'b1;
        wr(12'h008, 32'h1);
        chk("t4 flush valid", 64'(cmd_valid[0]), 64'h0);
        cmd_ready[0] = 1'b0;
        rd_chk("t4 flush level", 12'h000, 32'h0);

        // 5: done counter and clear collision
        for (int i = 0; i < 5; i++) begin
            cmd_done[0] = 1'b1;
            idle();
            idle();
        end
        rd_chk("t5 done5", 12'h008, 32'h5);
        cmd_done[0] = 1'b1;
        wr(12'h008, 32'h4);
        rd_chk("t5 done clear+pulse", 12'h008, 32'h1);
        chk("t5 irq off", 64'(irq), 64'h0);
        wr(12'h00C, 32'h1);
        idle();
        chk("t5 irq on", 64'(irq), 64'h1);
        wr(12'h00C, 32'h0);
        idle();
        chk("t5 irq off again", 64'(irq), 64'h0);

        // 6: async reset mid-stream
        for (int i = 0; i < 10; i++) begin
            wr(12'h000, 32'h100 + 32'(i));
            wr(12'h004, 32'h200 + 32'(i));
        end
        rd_chk("t6 level10", 12'h000, 32'd10);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6 async valid", 64'(cmd_valid), 64'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        rd_chk("t6 level q0", 12'h000, 32'h0);
        rd_chk("t6 status q0", 12'h004, 32'h1);
        rd_chk("t6 done q0", 12'h008, 32'h0);
        rd_chk("t6 irq_en q0", 12'h00C, 32'h0);
        rd_chk("t6 status q1", 12'h014, 32'h1);
        chk("t6 irq", 64'(irq), 64'h0);
        idle();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
